// File: rtl/serdes_pkg.sv
// Shared types and helpers for param_serdes. Frame length depends on the
// SERDES_PARITY_EN macro (appends one even-parity bit per frame when defined).
package serdes_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

    function automatic int frame_len(input int width);
`ifdef SERDES_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    // Callers zero-extend narrower words; zeros do not change the parity.
    function automatic logic even_parity(input logic [31:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/serdes_shift_rx.sv
// RX lane: collects serial bits, discards partial frames on an enable gap and
// emits the reassembled word with a one-cycle valid pulse (parity per SERDES_PARITY_EN).
module serdes_shift_rx
    import serdes_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             perr_o
);

    localparam int FRAME_LEN = frame_len(WIDTH);
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_LEN-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0]     data_q;
    logic [WIDTH-1:0]     word_d;
    logic                 valid_q;
    logic                 complete;

    // Bits enter at the top, so once a frame is in, index 0 holds the first arrival.
    assign shreg_d  = {bit_i, shreg_q[FRAME_LEN-1:1]};
    assign complete = en_i && (cnt_q == LAST_IDX);

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || complete) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
            if (MSB_FIRST) begin : g_msb
                assign word_d[gi] = shreg_d[WIDTH-1-gi];
            end else begin : g_lsb
                assign word_d[gi] = shreg_d[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= complete;
            if (en_i) begin
                shreg_q <= shreg_d;
            end
            if (complete) begin
                data_q <= word_d;
            end
        end
    end

`ifdef SERDES_PARITY_EN
    logic perr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if (complete) begin
            perr_q <= even_parity(32'(word_d)) ^ shreg_d[WIDTH];
        end
    end

    assign perr_o = perr_q;
`else
    assign perr_o = 1'b0;
`endif

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/param_serdes.sv
// Parametrised serializer/deserializer with valid/ready TX, loopback and
// optional even parity (SERDES_PARITY_EN).
module param_serdes
    import serdes_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             ser_out,
    output logic             ser_out_vld,
    input  logic             ser_in,
    input  logic             rx_en,
    input  logic             loopback,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_parity_err
);

    localparam int FRAME_LEN = frame_len(WIDTH);
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FRAME_LEN-1:0] frame_q, frame_d;
    logic                 ser_out_q, ser_out_d;
    logic                 vld_q, vld_d;
    logic [FRAME_LEN-1:0] load_frame;
    logic                 last_bit;
    logic                 accept;

    // load_frame is the word rearranged into transmission order (bit 0 goes first).
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_load
            if (MSB_FIRST) begin : g_msb
                assign load_frame[gi] = tx_data[WIDTH-1-gi];
            end else begin : g_lsb
                assign load_frame[gi] = tx_data[gi];
            end
        end
    endgenerate

`ifdef SERDES_PARITY_EN
    assign load_frame[WIDTH] = even_parity(32'(tx_data));
`endif

    assign last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST_IDX);
    assign tx_ready = (state_q == IDLE) || last_bit;
    assign accept   = tx_valid && tx_ready;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        ser_out_d = ser_out_q;
        vld_d     = vld_q;
        if (accept) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            ser_out_d = load_frame[0];
            vld_d     = 1'b1;
            frame_d   = load_frame >> 1;
        end else if (last_bit) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            ser_out_d = IDLE_LEVEL;
            vld_d     = 1'b0;
        end else if (state_q == SHIFT) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            ser_out_d = frame_q[0];
            frame_d   = frame_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            ser_out_q <= IDLE_LEVEL;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            ser_out_q <= ser_out_d;
            vld_q     <= vld_d;
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_out_vld = vld_q;

    logic rx_bit;
    logic rx_bit_en;

    assign rx_bit    = loopback ? ser_out_q : ser_in;
    assign rx_bit_en = loopback ? vld_q : rx_en;

    serdes_shift_rx #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .bit_i   (rx_bit),
        .en_i    (rx_bit_en),
        .data_o  (rx_data),
        .valid_o (rx_valid),
        .perr_o  (rx_parity_err)
    );

endmodule

// File: tb/tb_param_serdes.sv
// Directed bench for param_serdes: an LSB-first instance for TX/loopback/RX
// checks and an MSB-first instance for bit-order reassembly.
module tb_param_serdes;

`ifdef SERDES_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ser_out;
    logic       ser_out_vld;
    logic       ser_in = 1'b0;
    logic       rx_en = 1'b0;
    logic       loopback = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_err;

    logic [7:0] m_tx_data = 8'h00;
    logic       m_tx_valid = 1'b0;
    logic       m_tx_ready;
    logic       m_ser_out;
    logic       m_ser_out_vld;
    logic       m_ser_in = 1'b0;
    logic       m_rx_en = 1'b0;
    logic       m_loopback = 1'b0;
    logic [7:0] m_rx_data;
    logic       m_rx_valid;
    logic       m_rx_parity_err;

    param_serdes #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ser_out(ser_out), .ser_out_vld(ser_out_vld),
        .ser_in(ser_in), .rx_en(rx_en), .loopback(loopback),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err)
    );

    param_serdes #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .tx_data(m_tx_data), .tx_valid(m_tx_valid),
        .tx_ready(m_tx_ready), .ser_out(m_ser_out), .ser_out_vld(m_ser_out_vld),
        .ser_in(m_ser_in), .rx_en(m_rx_en), .loopback(m_loopback),
        .rx_data(m_rx_data), .rx_valid(m_rx_valid), .rx_parity_err(m_rx_parity_err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int         pulse_cyc[$];
    logic [7:0] pulse_data[$];
    logic       pulse_perr[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rx_valid) begin
            pulse_cyc.push_back(cyc);
            pulse_data.push_back(rx_data);
            pulse_perr.push_back(rx_parity_err);
        end
    endtask

    task automatic clear_pulses();
        pulse_cyc.delete();
        pulse_data.delete();
        pulse_perr.delete();
    endtask

    task automatic send_word(input logic [7:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    // Drive one LSB-first frame (parity bit appended when enabled) on ser_in.
    task automatic drive_ext(input logic [7:0] w, input logic par);
        for (int i = 0; i < FL; i++) begin
            ser_in = (i < 8) ? w[i] : par;
            rx_en  = 1'b1;
            step();
        end
        rx_en  = 1'b0;
        ser_in = 1'b0;
    endtask

    logic [7:0] a5_bits;
    logic [8:0] c1_bits;

    initial begin
        // Test 1: reset state and 0xA5 serialisation, LSB first
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_ser_out", 32'(ser_out), 32'd0);
        check_eq("rst_vld", 32'(ser_out_vld), 32'd0);
        check_eq("rst_tx_ready", 32'(tx_ready), 32'd1);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_rx_data", 32'(rx_data), 32'd0);
        check_eq("rst_perr", 32'(rx_parity_err), 32'd0);

        a5_bits = 8'b1010_0101;
        send_word(8'hA5);
        tx_data = 8'h00;
        for (int i = 0; i < FL; i++) begin
            check_eq($sformatf("a5_bit%0d", i), 32'(ser_out), 32'((i < 8) ? a5_bits[i] : 1'b0));
            check_eq($sformatf("a5_vld%0d", i), 32'(ser_out_vld), 32'd1);
            check_eq($sformatf("a5_rdy%0d", i), 32'(tx_ready), 32'(i == FL - 1));
            step();
        end
        check_eq("a5_after_vld", 32'(ser_out_vld), 32'd0);
        check_eq("a5_after_idle", 32'(ser_out), 32'd0);
        check_eq("a5_after_rdy", 32'(tx_ready), 32'd1);

        // Test 2: back-to-back 0x3C, 0xC3 in loopback
        loopback = 1'b1;
        step();
        clear_pulses();
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        step();
        tx_data = 8'hC3;
        for (int i = 0; i < FL; i++) begin
            check_eq($sformatf("b2b_rdy%0d", i), 32'(tx_ready), 32'(i == FL - 1));
            step();
        end
        tx_valid = 1'b0;
        check_eq("b2b_nogap_vld", 32'(ser_out_vld), 32'd1);
        check_eq("b2b_c3_bit0", 32'(ser_out), 32'd1);
        for (int i = 0; i < FL + 3; i++) step();
        check_eq("b2b_pulses", 32'(pulse_cyc.size()), 32'd2);
        if (pulse_cyc.size() == 2) begin
            check_eq("b2b_data0", 32'(pulse_data[0]), 32'h3C);
            check_eq("b2b_data1", 32'(pulse_data[1]), 32'hC3);
            check_eq("b2b_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'(FL));
            check_eq("b2b_perr0", 32'(pulse_perr[0]), 32'd0);
        end
        check_eq("b2b_hold", 32'(rx_data), 32'hC3);

        // Test 3: MSB-first reassembly from external ser_in
        c1_bits = {1'b1, 8'b1000_0011};
        for (int i = 0; i < FL; i++) begin
            m_ser_in = c1_bits[i];
            m_rx_en  = 1'b1;
            step();
        end
        m_rx_en = 1'b0;
        check_eq("msb_valid", 32'(m_rx_valid), 32'd1);
        check_eq("msb_data", 32'(m_rx_data), 32'hC1);
        step();
        check_eq("msb_valid_drop", 32'(m_rx_valid), 32'd0);
        check_eq("msb_data_hold", 32'(m_rx_data), 32'hC1);

        // Test 4: partial frame discarded by an rx_en gap
        loopback = 1'b0;
        step();
        clear_pulses();
        for (int i = 0; i < 5; i++) begin
            ser_in = 1'b1;
            rx_en  = 1'b1;
            step();
        end
        rx_en  = 1'b0;
        ser_in = 1'b0;
        step();
        drive_ext(8'h0F, 1'b0);
        step();
        step();
        check_eq("gap_pulses", 32'(pulse_cyc.size()), 32'd1);
        if (pulse_cyc.size() == 1) begin
            check_eq("gap_data", 32'(pulse_data[0]), 32'h0F);
        end

        // Test 5: reset mid-frame in loopback, then a clean 0x81
        loopback = 1'b1;
        step();
        clear_pulses();
        send_word(8'hFF);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_ser_out", 32'(ser_out), 32'd0);
        check_eq("midrst_vld", 32'(ser_out_vld), 32'd0);
        check_eq("midrst_rdy", 32'(tx_ready), 32'd1);
        check_eq("midrst_rx_data", 32'(rx_data), 32'd0);
        for (int i = 0; i < FL + 2; i++) step();
        check_eq("midrst_no_pulse", 32'(pulse_cyc.size()), 32'd0);
        send_word(8'h81);
        for (int i = 0; i < FL + 2; i++) step();
        check_eq("post_rst_pulses", 32'(pulse_cyc.size()), 32'd1);
        if (pulse_cyc.size() == 1) begin
            check_eq("post_rst_data", 32'(pulse_data[0]), 32'h81);
        end

`ifdef SERDES_PARITY_EN
        // Test 6: parity generation and checking
        clear_pulses();
        send_word(8'h07);
        for (int i = 0; i < 8; i++) step();
        check_eq("par_bit9", 32'(ser_out), 32'd1);
        check_eq("par_bit9_vld", 32'(ser_out_vld), 32'd1);
        for (int i = 0; i < 3; i++) step();
        check_eq("par_lb_pulses", 32'(pulse_cyc.size()), 32'd1);
        if (pulse_cyc.size() == 1) begin
            check_eq("par_lb_data", 32'(pulse_data[0]), 32'h07);
            check_eq("par_lb_perr", 32'(pulse_perr[0]), 32'd0);
        end
        loopback = 1'b0;
        step();
        clear_pulses();
        drive_ext(8'h07, 1'b0);
        step();
        check_eq("par_ext_pulses", 32'(pulse_cyc.size()), 32'd1);
        if (pulse_cyc.size() == 1) begin
            check_eq("par_ext_data", 32'(pulse_data[0]), 32'h07);
            check_eq("par_ext_perr", 32'(pulse_perr[0]), 32'd1);
        end
`else
        check_eq("noparity_perr", 32'(rx_parity_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_serdes.md
Name: param_serdes

Overview:
Parametrised serializer/deserializer with independent TX and RX lanes. It generalises the fixed 8-bit serdes with these additions:
- WIDTH-bit frames
- selectable bit order
- valid/ready handshake on the parallel TX side
- a per-bit frame marker
- an internal loopback mode
It sits between the pad-level serial pins and the parallel user logic in the tile top.

Parameters:
- WIDTH, 8, parallel word width in bits; legal range 2..32.
- MSB_FIRST, 0, bit order. 0 = LSB shifted out/in first; 1 = MSB first.
- IDLE_LEVEL, 0, value driven on ser_out when no frame is in flight.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  WIDTH  parallel word to serialize.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  TX can accept a word this cycle.
- ser_out  output  1  serial data out, registered.
- ser_out_vld  output  1  high on every cycle ser_out carries a frame bit.
- ser_in  input  1  serial data in.
- rx_en  input  1  ser_in carries a frame bit this cycle.
- loopback  input  1  when 1, RX samples ser_out/ser_out_vld instead of ser_in/rx_en.
- rx_data  output  WIDTH  last completed deserialized word.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- rx_parity_err  output  1  parity error flag, qualified by rx_valid.

Behaviour:
- Reset (rst=1 at a clock edge):
  - TX goes to IDLE.
  - ser_out=IDLE_LEVEL, ser_out_vld=0, tx_ready=1.
  - rx_data=0, rx_valid=0, rx_parity_err=0, all bit counters=0.
  - Reset mid-frame abandons the frame in both lanes; nothing partial is emitted.
- FRAME_LEN = WIDTH, or WIDTH+1 when parity is enabled.
- TX FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT on tx_valid && tx_ready. The word loads into the shift register and bit_cnt is cleared.
  - In SHIFT, ser_out/ser_out_vld present bit bit_cnt. bit_cnt increments each cycle.
  - Latency: the first bit appears on ser_out the cycle after the accepting edge.
  - tx_ready = (state==IDLE) || (state==SHIFT && bit_cnt==FRAME_LEN-1). This allows back-to-back frames with no gap.
  - On the last bit: if a new word is accepted, stay in SHIFT and reload; otherwise go to IDLE.
  - In IDLE: ser_out=IDLE_LEVEL, ser_out_vld=0.
  - tx_data is sampled only at the accept edge; later changes are ignored.
- RX:
  - rx_src/rx_en_i = loopback ? (ser_out, ser_out_vld) : (ser_in, rx_en).
  - Each cycle rx_en_i=1, the bit is shifted in and rx_cnt increments.
  - A cycle with rx_en_i=0 while 0<rx_cnt discards the partial frame (rx_cnt := 0).
  - When rx_cnt reaches FRAME_LEN-1 and another bit is taken:
    - next cycle rx_data holds the reassembled word (same bit order as TX);
    - rx_valid=1 for exactly one cycle;
    - rx_cnt wraps to 0.
  - Back-to-back frames produce rx_valid pulses FRAME_LEN cycles apart.
  - rx_data holds its value between pulses.
- Toggling loopback mid-frame has undefined data, but counters must stay consistent: the discard rule applies.

Optional Feature:
- Macro: SERDES_PARITY_EN.
- Defined:
  - TX appends an even-parity bit (XOR of the WIDTH data bits) as the final frame bit; FRAME_LEN=WIDTH+1.
  - RX checks parity. rx_parity_err is registered alongside rx_valid and is 1 when parity mismatches.
  - rx_data is still updated on an error.
- Undefined:
  - FRAME_LEN=WIDTH.
  - rx_parity_err is tied to 0.

Decomposition:
- Package serdes_pkg holds:
  - the TX state enum (IDLE, SHIFT);
  - function frame_len(WIDTH) that respects SERDES_PARITY_EN;
  - function even_parity.
- One sub-module, serdes_shift_rx: RX shift register, rx_cnt and discard/complete logic, parameterised by WIDTH/MSB_FIRST.
- The TX FSM stays in the top.

Test Plan:
1. WIDTH=8, MSB_FIRST=0, parity off. Apply rst for 2 cycles -> ser_out=0, ser_out_vld=0, tx_ready=1, rx_valid=0. Send tx_data=0xA5 -> ser_out sequence 1,0,1,0,0,1,0,1 on cycles 1..8 after accept; ser_out_vld high for exactly those 8 cycles.
2. loopback=1. Send 0x3C then 0xC3 with tx_valid held -> tx_ready high on the last bit of 0x3C, no gap cycle. rx_valid pulses twice, 8 cycles apart, with rx_data=0x3C then 0xC3.
3. MSB_FIRST=1, external ser_in. Drive 1,1,0,0,0,0,0,1 with rx_en=1 -> rx_data=0xC1, rx_valid pulse one cycle after the 8th bit.
4. External RX. Drive 5 bits, drop rx_en for 1 cycle, then drive 8 bits of 0x0F -> exactly one rx_valid, rx_data=0x0F.
5. Assert rst at bit 4 of a 0xFF transmit in loopback -> ser_out=0 and tx_ready=1 next cycle, no rx_valid. A subsequent 0x81 loops back correctly.
6. SERDES_PARITY_EN defined, loopback. Send 0x07 -> 9th bit=1, rx_valid with rx_parity_err=0. Externally drive 0x07 with parity bit 0 -> rx_parity_err=1 on the rx_valid cycle.
